// File: rtl/pcileech_sysctl.sv
// rtl/pcileech_sysctl.sv - board system controller: POR hold, button debounce, tick counter, LED modes
module pcileech_sysctl #(
    parameter int NUM_BTN         = 2,
    parameter int NUM_LED         = 3,
    parameter int POR_CYCLES      = 64,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int STRETCH_CYCLES  = 5000000,
    parameter int BLINK_BIT       = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   btn_in,
    input  logic [NUM_BTN-1:0]   btn_rst_mask,
    input  logic [2*NUM_LED-1:0] led_mode,
    input  logic [NUM_LED-1:0]   led_act,
    input  logic                 led_invert,
    output logic [NUM_BTN-1:0]   btn_db,
    output logic [NUM_BTN-1:0]   btn_press,
    output logic                 rst_sys,
    output logic                 rst_sys_n,
    output logic [63:0]          tickcount64,
    output logic [NUM_LED-1:0]   led
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int POR_W = $clog2(POR_CYCLES + 1);
    localparam int ST_W  = $clog2(STRETCH_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [POR_W-1:0] POR_MAX  = POR_W'(POR_CYCLES);
    localparam logic [ST_W-1:0]  ST_LOAD  = ST_W'(STRETCH_CYCLES);

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] btn_db_q;
    logic [DB_W-1:0]    db_cnt [NUM_BTN];
    logic [POR_W-1:0]   por_cnt;
    logic               rst_req;
    logic [ST_W-1:0]    stretch [NUM_LED];
    logic [NUM_LED-1:0] mode_out;

    // Free-running cycle counter; only the board reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tickcount64 <= 64'd0;
        end else begin
            tickcount64 <= tickcount64 + 64'd1;
        end
    end

    // Synchronize buttons, debounce by requiring a stable differing level, flag rising edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            btn_db    <= '0;
            btn_db_q  <= '0;
            btn_press <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1     <= btn_in;
            sync2     <= sync1;
            btn_db_q  <= btn_db;
            btn_press <= btn_db & ~btn_db_q;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_db[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Power-on hold counter, saturates once the hold has elapsed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            por_cnt <= '0;
        end else if (por_cnt != POR_MAX) begin
            por_cnt <= por_cnt + POR_W'(1);
        end
    end

    // System reset request: POR still running or any reset-capable button held
    always_comb begin
        rst_req = (por_cnt < POR_MAX) | (|(btn_db & btn_rst_mask));
    end

    // Both reset polarities come from the same edge so they never disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sys   <= 1'b1;
            rst_sys_n <= 1'b0;
        end else begin
            rst_sys   <= rst_req;
            rst_sys_n <= ~rst_req;
        end
    end

    // Activity stretchers reload on every pulse and run down regardless of LED mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LED; i++) begin
                stretch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LED; i++) begin
                if (led_act[i]) begin
                    stretch[i] <= ST_LOAD;
                end else if (stretch[i] != '0) begin
                    stretch[i] <= stretch[i] - ST_W'(1);
                end
            end
        end
    end

    // Per-LED mode selection
    always_comb begin
        mode_out = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (led_mode[2*i +: 2])
                2'd0:    mode_out[i] = 1'b0;
                2'd1:    mode_out[i] = 1'b1;
                2'd2:    mode_out[i] = tickcount64[BLINK_BIT];
                default: mode_out[i] = (stretch[i] != '0);
            endcase
        end
    end

    // Registered LED drive with global polarity inversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= mode_out ^ {NUM_LED{led_invert}};
        end
    end

endmodule

// File: tb/tb_pcileech_sysctl.sv
// tb/tb_pcileech_sysctl.sv - scoreboard bench for pcileech_sysctl
module tb_pcileech_sysctl;

    localparam int NB  = 2;
    localparam int NL  = 3;
    localparam int POR = 16;
    localparam int DBC = 4;
    localparam int STR = 8;
    localparam int BLK = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_rst_mask;
    logic [2*NL-1:0] led_mode;
    logic [NL-1:0] led_act;
    logic          led_invert;
    logic [NB-1:0] btn_db;
    logic [NB-1:0] btn_press;
    logic          rst_sys;
    logic          rst_sys_n;
    logic [63:0]   tickcount64;
    logic [NL-1:0] led;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcileech_sysctl #(
        .NUM_BTN(NB), .NUM_LED(NL), .POR_CYCLES(POR),
        .DEBOUNCE_CYCLES(DBC), .STRETCH_CYCLES(STR), .BLINK_BIT(BLK)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_rst_mask(btn_rst_mask),
        .led_mode(led_mode), .led_act(led_act), .led_invert(led_invert),
        .btn_db(btn_db), .btn_press(btn_press), .rst_sys(rst_sys),
        .rst_sys_n(rst_sys_n), .tickcount64(tickcount64), .led(led)
    );

    typedef struct {
        logic [63:0]   tick;
        logic [NB-1:0] db;
        logic [NB-1:0] press;
        logic          rs;
        logic [NL-1:0] led;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: outputs after edge e, derived from input history since reset release
    int            n;
    logic [NB-1:0] hist[$];
    logic [NB-1:0] db1, db2;
    int            last_act [NL];

    always @(posedge clk) begin : model
        exp_t          ex;
        int            e;
        logic [NB-1:0] smp, db_new;
        logic          v, all_same, m;
        if (rst) begin
            n = 0;
            hist.delete();
            db1 = '0;
            db2 = '0;
            for (int i = 0; i < NL; i++) last_act[i] = -1000000;
            ex.tick = 64'd0; ex.db = '0; ex.press = '0; ex.rs = 1'b1; ex.led = '0;
            q.push_back(ex);
        end else begin
            e = n + 1;
            ex.tick  = 64'(e);
            ex.press = db1 & ~db2;
            ex.rs    = ((e - 1) < POR) || ((db1 & btn_rst_mask) != '0);
            for (int i = 0; i < NL; i++) begin
                case (led_mode[2*i +: 2])
                    2'd0:    m = 1'b0;
                    2'd1:    m = 1'b1;
                    2'd2:    m = (((e - 1) >> BLK) & 1) != 0;
                    default: m = (last_act[i] >= e - STR);
                endcase
                ex.led[i] = m ^ led_invert;
                if (led_act[i]) last_act[i] = e;
            end
            // Button level seen by the debouncer lags the pin by two edges; it is
            // accepted once DBC consecutive such samples all disagree with btn_db.
            hist.push_front(btn_in);
            if (hist.size() > DBC + 2) void'(hist.pop_back());
            db_new = db1;
            for (int b = 0; b < NB; b++) begin
                smp = (2 < hist.size()) ? hist[2] : '0;
                v = smp[b];
                all_same = 1'b1;
                for (int k = 2; k <= DBC + 1; k++) begin
                    smp = (k < hist.size()) ? hist[k] : '0;
                    if (smp[b] != v) all_same = 1'b0;
                end
                if (all_same && (v != db1[b])) db_new[b] = v;
            end
            db2 = db1;
            db1 = db_new;
            ex.db = db_new;
            n = e;
            q.push_back(ex);
        end
    end

    // Monitor: compare every registered output once per cycle, away from the active edge
    always @(negedge clk) begin : monitor
        exp_t ex;
        logic rsn;
        if (q.size() > 0) begin
            ex = q.pop_front();
            rsn = ~ex.rs;
            chk("tickcount64", tickcount64, ex.tick);
            chk("btn_db", 64'(btn_db), 64'(ex.db));
            chk("btn_press", 64'(btn_press), 64'(ex.press));
            chk("rst_sys", 64'(rst_sys), 64'(ex.rs));
            chk("rst_sys_n", 64'(rst_sys_n), 64'(rsn));
            chk("led", 64'(led), 64'(ex.led));
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic hit_reset(input int hold);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_tick", tickcount64, 64'd0);
        chk("async_outs", 64'({btn_db, btn_press, led, rst_sys, rst_sys_n}), 64'(9'b0000_000_10));
        cyc(hold);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_in = '0; btn_rst_mask = '0; led_mode = '0; led_act = '0; led_invert = 1'b0;
        cyc(3);
        @(negedge clk);
        #1 rst = 1'b0;
        cyc(16);
        chk("por_hold_16", 64'(rst_sys), 64'd1);
        chk("tick_16", tickcount64, 64'd16);
        cyc(1);
        chk("por_release_17", 64'(rst_sys), 64'd0);
        cyc(4);

        // short glitch then a clean 10-cycle level on button 0
        btn_in = 2'b01; cyc(3); btn_in = 2'b00; cyc(8);
        chk("glitch_no_db", 64'(btn_db), 64'd0);
        btn_in = 2'b01; cyc(5);
        chk("db_not_yet", 64'(btn_db[0]), 64'd0);
        cyc(1);
        chk("db_rise_6", 64'(btn_db[0]), 64'd1);
        cyc(1);
        chk("press_pulse", 64'(btn_press[0]), 64'd1);
        cyc(1);
        chk("press_single", 64'(btn_press[0]), 64'd0);
        cyc(2);
        btn_in = 2'b00; cyc(5);
        chk("db_still_high", 64'(btn_db[0]), 64'd1);
        cyc(1);
        chk("db_fall_6", 64'(btn_db[0]), 64'd0);
        cyc(4);

        // reset-capable button, then the same button with masking off
        btn_rst_mask = 2'b01;
        btn_in = 2'b01; cyc(6);
        chk("mask_db_up", 64'(btn_db[0]), 64'd1);
        chk("mask_rs_lag", 64'(rst_sys), 64'd0);
        cyc(1);
        chk("mask_rs_up", 64'(rst_sys), 64'd1);
        cyc(13);
        btn_in = 2'b00; cyc(6);
        chk("mask_rs_hold", 64'(rst_sys), 64'd1);
        cyc(1);
        chk("mask_rs_down", 64'(rst_sys), 64'd0);
        cyc(4);
        btn_rst_mask = 2'b00;
        btn_in = 2'b01; cyc(20); btn_in = 2'b00; cyc(10);

        // activity stretch with a retrigger five cycles in
        led_mode = 6'b11_00_00; cyc(2);
        led_act = 3'b100; cyc(1); led_act = 3'b000;
        chk("stretch_lag", 64'(led[2]), 64'd0);
        cyc(1);
        chk("stretch_on", 64'(led[2]), 64'd1);
        cyc(3);
        led_act = 3'b100; cyc(1); led_act = 3'b000;
        cyc(8);
        chk("stretch_extended", 64'(led[2]), 64'd1);
        cyc(1);
        chk("stretch_off", 64'(led[2]), 64'd0);
        cyc(3);

        // heartbeat / on / off, then inversion
        led_mode = 6'b10_01_00; cyc(20);
        led_invert = 1'b1; cyc(10);
        led_invert = 1'b0; cyc(3);

        // reset in the middle of a stretch and a debounce
        led_mode = 6'b11_00_00;
        led_act = 3'b100; cyc(1); led_act = 3'b000;
        btn_in = 2'b10; cyc(2);
        hit_reset(2);
        btn_in = 2'b00;
        cyc(16);
        chk("por2_hold_16", 64'(rst_sys), 64'd1);
        cyc(1);
        chk("por2_release_17", 64'(rst_sys), 64'd0);

        // randomized traffic
        for (int it = 0; it < 800; it++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(9) == 0) btn_in[b] = ~btn_in[b];
            if ($urandom_range(49) == 0) btn_rst_mask = NB'($urandom);
            if ($urandom_range(29) == 0) led_mode = (2*NL)'($urandom);
            for (int i = 0; i < NL; i++) led_act[i] = ($urandom_range(7) == 0);
            if ($urandom_range(39) == 0) led_invert = ~led_invert;
            if (it == 400) hit_reset(1 + $urandom_range(3));
            cyc(1);
        end

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
